// File: rtl/coletor_serial.sv
// rtl/coletor_serial.sv - serial-to-parallel collector with popcount and a one-word output register
module coletor_serial #(
  parameter int LARGURA = 8,
  parameter int CW      = $clog2(LARGURA + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic [LARGURA-1:0] dado_out,
  output logic               dado_valid,
  input  logic               dado_ready,
  output logic [CW-1:0]      contagem_uns,
  output logic               overflow
);

  localparam int CNTW = $clog2(LARGURA);
  localparam logic [CNTW-1:0] ULTIMO = CNTW'(LARGURA - 1);

  typedef enum logic {VAZIO = 1'b0, CHEIO = 1'b1} estado_t;

  estado_t            estado_q;
  logic [LARGURA-1:0] shift_q;
  logic [LARGURA-1:0] dado_q;
  logic [LARGURA-1:0] palavra_d;
  logic [CNTW-1:0]    cnt_q;
  logic [CNTW-1:0]    cnt_d;
  logic [CW-1:0]      contagem_q;
  logic [CW-1:0]      contagem_d;
  logic               overflow_q;
  logic               completa;

  // The completed word already contains the bit sampled on this edge.
  always_comb begin
    palavra_d  = {shift_q[LARGURA-2:0], bit_in};
    completa   = bit_valid && (cnt_q == ULTIMO);
    cnt_d      = completa ? '0 : cnt_q + CNTW'(1);
    contagem_d = '0;
    for (int i = 0; i < LARGURA; i++) begin
      contagem_d = contagem_d + CW'(palavra_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q   <= VAZIO;
      shift_q    <= '0;
      cnt_q      <= '0;
      dado_q     <= '0;
      contagem_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (bit_valid) begin
        shift_q <= palavra_d;
        cnt_q   <= cnt_d;
      end
      case (estado_q)
        VAZIO: begin
          if (completa) begin
            dado_q     <= palavra_d;
            contagem_q <= contagem_d;
            estado_q   <= CHEIO;
          end
        end
        CHEIO: begin
          if (completa) begin
            // A word arriving while the held one is not being drained is lost.
            if (dado_ready) begin
              dado_q     <= palavra_d;
              contagem_q <= contagem_d;
            end else begin
              overflow_q <= 1'b1;
            end
          end else if (dado_ready) begin
            estado_q <= VAZIO;
          end
        end
        default: estado_q <= VAZIO;
      endcase
    end
  end

  assign dado_out     = dado_q;
  assign dado_valid   = (estado_q == CHEIO);
  assign contagem_uns = contagem_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_coletor_serial.sv
// tb/tb_coletor_serial.sv - directed scoreboard bench for coletor_serial
module tb_coletor_serial;

  logic       clk;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;
  logic [7:0] dado_out;
  logic       dado_valid;
  logic       dado_ready;
  logic [3:0] contagem_uns;
  logic       overflow;

  int n_vec;
  int n_err;
  logic [11:0] sb_q[$];

  coletor_serial #(.LARGURA(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .dado_out     (dado_out),
    .dado_valid   (dado_valid),
    .dado_ready   (dado_ready),
    .contagem_uns (contagem_uns),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] w);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) c = c + {3'd0, w[i]};
    sb_q.push_back({c, w});
  endtask

  // Drives one word MSB first; inputs change 1 time unit after the rising edge.
  task automatic send_word(input logic [7:0] w, input bit gap, input bit quiet, input bit ready_last);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0 && ready_last) dado_ready = 1'b1;
      bit_in    = w[i];
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      bit_valid = 1'b0;
      if (quiet && i > 0) chk("quiet_before_last_bit", {31'd0, dado_valid}, 32'd0);
      if (gap && i > 0) begin
        @(posedge clk);
        #1;
        if (quiet) chk("quiet_in_gap", {31'd0, dado_valid}, 32'd0);
      end
    end
  endtask

  task automatic check_out(input string tag);
    logic [11:0] e;
    if (sb_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, {31'd0, dado_valid}, 32'd1);
      chk({tag, "_data"}, {24'd0, dado_out}, {24'd0, e[7:0]});
      chk({tag, "_ones"}, {28'd0, contagem_uns}, {28'd0, e[11:8]});
    end
  endtask

  initial begin
    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    dado_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", {31'd0, dado_valid}, 32'd0);
    chk("rst_data", {24'd0, dado_out}, 32'd0);
    chk("rst_ones", {28'd0, contagem_uns}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    // Basic capture, then accept on the following edge.
    dado_ready = 1'b1;
    push_exp(8'hB2);
    send_word(8'hB2, 1'b0, 1'b1, 1'b0);
    check_out("basic");
    @(posedge clk);
    #1;
    chk("basic_drained", {31'd0, dado_valid}, 32'd0);

    // Gapped input produces the same word.
    push_exp(8'hB2);
    send_word(8'hB2, 1'b1, 1'b1, 1'b0);
    check_out("gapped");
    @(posedge clk);
    #1;
    chk("gapped_drained", {31'd0, dado_valid}, 32'd0);

    // Backpressure: second word is dropped and overflow sticks.
    dado_ready = 1'b0;
    push_exp(8'hFF);
    send_word(8'hFF, 1'b0, 1'b0, 1'b0);
    check_out("bp_first");
    chk("bp_ovf_before", {31'd0, overflow}, 32'd0);
    send_word(8'h0F, 1'b0, 1'b0, 1'b0);
    chk("bp_valid_held", {31'd0, dado_valid}, 32'd1);
    chk("bp_data_held", {24'd0, dado_out}, 32'hFF);
    chk("bp_ones_held", {28'd0, contagem_uns}, 32'd8);
    chk("bp_ovf_set", {31'd0, overflow}, 32'd1);
    dado_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drained", {31'd0, dado_valid}, 32'd0);
    chk("bp_ovf_sticky", {31'd0, overflow}, 32'd1);
    chk("bp_data_hold_empty", {24'd0, dado_out}, 32'hFF);

    // Reset with a pending word and overflow set; reset beats bit_valid/dado_ready.
    dado_ready = 1'b0;
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_valid", {31'd0, dado_valid}, 32'd1);
    rst        = 1'b1;
    bit_in     = 1'b1;
    bit_valid  = 1'b1;
    dado_ready = 1'b1;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    bit_valid  = 1'b0;
    dado_ready = 1'b0;
    chk("clr_valid", {31'd0, dado_valid}, 32'd0);
    chk("clr_data", {24'd0, dado_out}, 32'd0);
    chk("clr_ones", {28'd0, contagem_uns}, 32'd0);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);

    // Accept and completion on the same edge reloads without overflow.
    push_exp(8'hA5);
    send_word(8'hA5, 1'b0, 1'b0, 1'b0);
    check_out("pend_a5");
    push_exp(8'h3C);
    send_word(8'h3C, 1'b0, 1'b0, 1'b1);
    check_out("reload_3c");
    chk("reload_ovf", {31'd0, overflow}, 32'd0);
    @(posedge clk);
    #1;
    chk("reload_drained", {31'd0, dado_valid}, 32'd0);

    // Reset mid-word discards the partial bits.
    for (int i = 0; i < 5; i++) begin
      bit_in    = 1'b1;
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bit_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst_valid", {31'd0, dado_valid}, 32'd0);
    push_exp(8'h81);
    send_word(8'h81, 1'b0, 1'b1, 1'b0);
    check_out("after_mid_rst");

    chk("scoreboard_drained", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coletor_serial.md
COLETOR_SERIAL -- requirements
Module: coletor_serial

Interface
REQ-001 The module SHALL have parameter LARGURA, default 8, giving the number of serial bits packed per word; the legal range is 2..16.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port bit_in, input, 1 bit: the serial data bit, driven by the mtpz output of the upstream logic stage.
REQ-005 The module SHALL have port bit_valid, input, 1 bit: when high, bit_in is sampled on this edge.
REQ-006 The module SHALL have port dado_out, output, LARGURA bits: the packed word, with the first received bit in the MSB.
REQ-007 The module SHALL have port dado_valid, output, 1 bit: when high, dado_out holds an unconsumed word.
REQ-008 The module SHALL have port dado_ready, input, 1 bit: the consumer accepts the word on an edge where dado_valid and dado_ready are both high.
REQ-009 The module SHALL have port contagem_uns, output, clog2(LARGURA+1) bits (4 for LARGURA=8): the number of 1 bits in dado_out.
REQ-010 The module SHALL have port overflow, output, 1 bit: a sticky flag indicating that a completed word was dropped.

Function
REQ-011 Shift register: on each edge with bit_valid=1, the module SHALL shift bit_in into the LSB of an internal shift register, with older bits moving toward the MSB.
REQ-012 Bit counter: the module SHALL count 0..LARGURA-1, increment only on bit_valid, and wrap to 0 on the LARGURA-th bit; edges with bit_valid=0 SHALL change no state except the handshake.
REQ-013 Word completion: the edge that samples the LARGURA-th bit completes the word; the completed value SHALL include that bit.
REQ-014 Output register, empty or being drained: when a word completes and the output register is empty, or is being drained on the same edge (dado_valid and dado_ready both high), the module SHALL load dado_out and contagem_uns with the completed word, and dado_valid SHALL be 1 after that edge.
REQ-015 Latency: dado_valid SHALL rise exactly 1 cycle after the edge that samples the LARGURA-th bit, i.e. it is registered with no combinational path from bit_in.
REQ-016 Output register, full: when a word completes while dado_valid=1 and dado_ready=0, the completed word SHALL be discarded.
REQ-017 Output register, full (cont.): in the case of REQ-016, dado_out and contagem_uns SHALL keep their old values, overflow SHALL be set to 1, and the bit counter SHALL still wrap to 0.
REQ-018 Handshake: when dado_valid=1, dado_ready=1, and no word completes on that edge, dado_valid SHALL clear to 0.
REQ-019 Holding: dado_out and contagem_uns SHALL hold their values while dado_valid=0.
REQ-020 Valid persistence: once high, dado_valid SHALL NOT drop until the word has been accepted.
REQ-021 Stability: dado_out SHALL NOT change while dado_valid=1 and dado_ready=0.
REQ-022 Population count: contagem_uns SHALL be computed from the completed word and registered together with dado_out; its range is 0..LARGURA.
REQ-023 Overflow: overflow SHALL remain 1 until rst; no other input clears it.
REQ-024 State machine: the module SHALL implement two states, VAZIO (dado_valid=0) and CHEIO (dado_valid=1).
REQ-025 Transitions from VAZIO: VAZIO->CHEIO on word completion.
REQ-026 Transitions from CHEIO: CHEIO->VAZIO on accept without completion; CHEIO->CHEIO on accept with completion (reload) or on completion without accept (overflow).

Reset
REQ-027 When rst=1 at a clock edge, the module SHALL clear to zero after that edge: the shift register, the bit counter, dado_out, dado_valid, contagem_uns, and overflow.
REQ-028 Reset SHALL take priority over bit_valid and dado_ready on the same edge.
REQ-029 A reset asserted mid-word SHALL discard the partial word; the next bit_valid after rst deasserts is bit 0 of a new word.
REQ-030 A reset asserted while dado_valid=1 SHALL drop the pending word without setting overflow.

Verification
REQ-031 Basic capture: with LARGURA=8 and dado_ready=1, send bits 1,0,1,1,0,0,1,0 on consecutive cycles -> one cycle after the 8th bit, dado_valid=1, dado_out=8'hB2, and contagem_uns=4.
REQ-032 Gapped input: send the same bits with bit_valid low on alternate cycles -> identical word; no dado_valid pulse before the 8th valid bit.
REQ-033 Backpressure and overflow: with dado_ready=0, send 16 bits (8'hFF then 8'h0F) -> dado_out stays 8'hFF with contagem_uns=8, overflow=1 after the 16th bit, and raising dado_ready then drops dado_valid.
REQ-034 Simultaneous accept and completion: hold 8'hA5 pending, then assert dado_ready on the edge that completes 8'h3C -> dado_valid stays 1, dado_out=8'h3C, contagem_uns=4, and overflow=0.
REQ-035 Reset mid-word: send 5 bits, pulse rst for 1 cycle, then send 8'h81 -> dado_out=8'h81 and contagem_uns=2.
REQ-036 Reset clears state: rst with overflow=1 and dado_valid=1 -> all outputs are 0 on the next cycle.
